// File: rtl/radiant_thresh_servo.sv
// Closed-loop threshold servo: counts trigger edges per channel over a gate, latches scalers,
// then walks the channels nudging each threshold toward the target rate via a req/ack write port.
module radiant_thresh_servo #(
  parameter int                     NCH         = 24,
  parameter int                     CNT_BITS    = 16,
  parameter int                     THRESH_BITS = 16,
  parameter int                     GATE_CYCLES = 1000000,
  parameter logic [THRESH_BITS-1:0] INIT_THRESH = 16'h8000,
  parameter int                     STEP        = 16,
  parameter logic [THRESH_BITS-1:0] THRESH_MIN  = 16'h0100,
  parameter logic [THRESH_BITS-1:0] THRESH_MAX  = 16'hFF00,
  parameter int                     ACK_TIMEOUT = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic [NCH-1:0]         trig_i,
  input  logic [CNT_BITS-1:0]    target_i,
  input  logic [CNT_BITS-1:0]    deadband_i,
  output logic                   thresh_wr_o,
  output logic [4:0]             thresh_ch_o,
  output logic [THRESH_BITS-1:0] thresh_dat_o,
  input  logic                   thresh_ack_i,
  input  logic [4:0]             scaler_sel_i,
  output logic [CNT_BITS-1:0]    scaler_o,
  output logic                   busy_o,
  output logic                   cycle_done_o,
  output logic                   timeout_o
);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int GW = $clog2(GATE_CYCLES);
  localparam int AW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [GW-1:0]          GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [AW-1:0]          ACK_LAST  = AW'(ACK_TIMEOUT - 1);
  localparam logic [IW-1:0]          CH_LAST   = IW'(NCH - 1);
  localparam logic [THRESH_BITS:0]   STEP_W    = (THRESH_BITS + 1)'(STEP);

  typedef enum logic [2:0] {S_IDLE, S_GATE, S_LATCH, S_EVAL, S_WRITE, S_NEXT} state_e;

  state_e                 state_q, state_d;
  logic [GW-1:0]          gate_q, gate_d;
  logic [AW-1:0]          ack_cnt_q, ack_cnt_d;
  logic [IW-1:0]          ch_q, ch_d;
  logic                   wr_q, wr_d;
  logic [4:0]             ch_o_q, ch_o_d;
  logic [THRESH_BITS-1:0] dat_q, dat_d;
  logic                   done_q, done_d;
  logic                   tmo_q, tmo_d;
  logic [NCH-1:0]         trig_q;
  logic [NCH-1:0]         edge_w;
  logic [CNT_BITS-1:0]    cnt_q [NCH];
  logic [CNT_BITS-1:0]    cnt_d [NCH];
  logic [CNT_BITS-1:0]    scal_q [NCH];
  logic [CNT_BITS-1:0]    scal_d [NCH];
  logic [THRESH_BITS-1:0] thr_q [NCH];
  logic [THRESH_BITS-1:0] thr_d [NCH];

  logic [CNT_BITS-1:0]    cur_cnt, lo;
  logic [CNT_BITS:0]      hi;
  logic [THRESH_BITS-1:0] cur_thr, new_thr;
  logic [THRESH_BITS:0]   up_w;

  assign edge_w = trig_i & ~trig_q;

  // Evaluation math is one bit wider than its operands so nothing wraps before clamping.
  always_comb begin
    cur_cnt = scal_q[ch_q];
    cur_thr = thr_q[ch_q];
    hi      = {1'b0, target_i} + {1'b0, deadband_i};
    lo      = (target_i > deadband_i) ? target_i - deadband_i : '0;
    up_w    = {1'b0, cur_thr} + STEP_W;
    new_thr = cur_thr;
    if ({1'b0, cur_cnt} > hi) begin
      new_thr = (up_w > {1'b0, THRESH_MAX}) ? THRESH_MAX : up_w[THRESH_BITS-1:0];
    end else if (cur_cnt < lo) begin
      new_thr = ({1'b0, cur_thr} < STEP_W + {1'b0, THRESH_MIN}) ? THRESH_MIN
              : cur_thr - STEP_W[THRESH_BITS-1:0];
    end
  end

  // Write port: thresh_wr_o stays high with ch/dat frozen until a cycle with thresh_ack_i=1
  // (transfer happens on that edge) or until ACK_TIMEOUT cycles elapse; ack is ignored while wr=0.
  always_comb begin
    state_d   = state_q;
    gate_d    = gate_q;
    ack_cnt_d = ack_cnt_q;
    ch_d      = ch_q;
    wr_d      = wr_q;
    ch_o_d    = ch_o_q;
    dat_d     = dat_q;
    done_d    = 1'b0;
    tmo_d     = tmo_q;
    cnt_d     = cnt_q;
    scal_d    = scal_q;
    thr_d     = thr_q;
    case (state_q)
      S_IDLE: begin
        if (enable_i) begin
          state_d = S_GATE;
          gate_d  = '0;
          for (int i = 0; i < NCH; i++) cnt_d[i] = '0;
        end
      end
      S_GATE: begin
        if (!enable_i) begin
          state_d = S_IDLE;
        end else begin
          for (int i = 0; i < NCH; i++) begin
            if (edge_w[i] && cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + 1'b1;
          end
          if (gate_q == GATE_LAST) state_d = S_LATCH;
          else gate_d = gate_q + 1'b1;
        end
      end
      S_LATCH: begin
        scal_d  = cnt_q;
        ch_d    = '0;
        state_d = enable_i ? S_EVAL : S_IDLE;
      end
      S_EVAL: begin
        if (!enable_i) begin
          state_d = S_IDLE;
        end else if (new_thr != cur_thr) begin
          wr_d      = 1'b1;
          ch_o_d    = 5'(ch_q);
          dat_d     = new_thr;
          ack_cnt_d = '0;
          state_d   = S_WRITE;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_WRITE: begin
        if (thresh_ack_i) begin
          thr_d[ch_q] = dat_q;
          wr_d        = 1'b0;
          state_d     = S_NEXT;
        end else if (ack_cnt_q == ACK_LAST) begin
          wr_d    = 1'b0;
          tmo_d   = 1'b1;
          state_d = S_NEXT;
        end else begin
          ack_cnt_d = ack_cnt_q + 1'b1;
        end
      end
      S_NEXT: begin
        if (!enable_i) begin
          state_d = S_IDLE;
        end else if (ch_q == CH_LAST) begin
          done_d  = 1'b1;
          state_d = S_GATE;
          gate_d  = '0;
          for (int i = 0; i < NCH; i++) cnt_d[i] = '0;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = S_EVAL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      gate_q    <= '0;
      ack_cnt_q <= '0;
      ch_q      <= '0;
      wr_q      <= 1'b0;
      ch_o_q    <= '0;
      dat_q     <= '0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
      trig_q    <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]  <= '0;
        scal_q[i] <= '0;
        thr_q[i]  <= INIT_THRESH;
      end
    end else begin
      state_q   <= state_d;
      gate_q    <= gate_d;
      ack_cnt_q <= ack_cnt_d;
      ch_q      <= ch_d;
      wr_q      <= wr_d;
      ch_o_q    <= ch_o_d;
      dat_q     <= dat_d;
      done_q    <= done_d;
      tmo_q     <= tmo_d;
      trig_q    <= trig_i;
      cnt_q     <= cnt_d;
      scal_q    <= scal_d;
      thr_q     <= thr_d;
    end
  end

  always_comb begin
    scaler_o = '0;
    if (32'(scaler_sel_i) < NCH) scaler_o = scal_q[scaler_sel_i[IW-1:0]];
  end

  assign thresh_wr_o  = wr_q;
  assign thresh_ch_o  = ch_o_q;
  assign thresh_dat_o = dat_q;
  assign busy_o       = (state_q != S_IDLE);
  assign cycle_done_o = done_q;
  assign timeout_o    = tmo_q;
endmodule

// File: tb/tb_radiant_thresh_servo.sv
// Directed bench for radiant_thresh_servo: short gates, a second small instance for clamp and
// counter saturation, a write log compared against hand-computed expected writes.
module tb_radiant_thresh_servo;
  localparam int NCH  = 24;
  localparam int GATE = 40;
  localparam int NCH2 = 4;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            enable = 1'b0;
  logic [NCH-1:0]  trig = '0;
  logic [15:0]     target = 16'd10, deadband = 16'd2;
  logic            ack = 1'b0;
  logic [4:0]      sel = 5'd0;
  logic            thresh_wr_o, busy_o, cycle_done_o, timeout_o;
  logic [4:0]      thresh_ch_o;
  logic [15:0]     thresh_dat_o, scaler_o;

  logic            enable2 = 1'b0;
  logic [NCH2-1:0] trig2 = '0;
  logic [3:0]      target2 = 4'd10, db2 = 4'd2;
  logic            ack2 = 1'b1;
  logic [4:0]      sel2 = 5'd0;
  logic            wr2, busy2, done2, tmo2;
  logic [4:0]      ch2;
  logic [15:0]     dat2;
  logic [3:0]      scal2;

  radiant_thresh_servo #(.NCH(NCH), .GATE_CYCLES(GATE)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .trig_i(trig), .target_i(target),
    .deadband_i(deadband), .thresh_wr_o(thresh_wr_o), .thresh_ch_o(thresh_ch_o),
    .thresh_dat_o(thresh_dat_o), .thresh_ack_i(ack), .scaler_sel_i(sel), .scaler_o(scaler_o),
    .busy_o(busy_o), .cycle_done_o(cycle_done_o), .timeout_o(timeout_o));

  radiant_thresh_servo #(.NCH(NCH2), .CNT_BITS(4), .GATE_CYCLES(GATE), .INIT_THRESH(16'hFEF8)) dut2 (
    .clk_i(clk), .rst_i(rst), .enable_i(enable2), .trig_i(trig2), .target_i(target2),
    .deadband_i(db2), .thresh_wr_o(wr2), .thresh_ch_o(ch2), .thresh_dat_o(dat2),
    .thresh_ack_i(ack2), .scaler_sel_i(sel2), .scaler_o(scal2), .busy_o(busy2),
    .cycle_done_o(done2), .timeout_o(tmo2));

  // ---------------- trigger driver ----------------
  logic [NCH-1:0] slow_mask = '0, fast_mask = '0, hold_mask = '0;
  logic           fast2 = 1'b0;
  logic [1:0]     ph = 2'd0;
  always @(negedge clk) begin
    ph    = ph + 2'd1;
    trig  = (fast_mask & {NCH{ph[0]}}) | (slow_mask & {NCH{ph[1]}}) | hold_mask;
    trig2 = {3'b000, fast2 & ph[0]};
  end

  // ---------------- ack driver / write monitor ----------------
  logic [20:0] log_q[$];
  logic [15:0] log2_q[$];
  int          done_cnt = 0, wr_hi3 = 0, nw2 = 0, done2_cnt = 0;
  logic        clr = 1'b0, hold_en = 1'b0;
  logic [4:0]  hold_ch = 5'd0;
  always @(posedge clk) begin
    #3;
    ack = thresh_wr_o && !(hold_en && thresh_ch_o == hold_ch);
    if (clr) begin
      log_q.delete();
      log2_q.delete();
      done_cnt = 0; wr_hi3 = 0; nw2 = 0; done2_cnt = 0;
    end else begin
      if (thresh_wr_o && ack) log_q.push_back({thresh_ch_o, thresh_dat_o});
      if (thresh_wr_o && thresh_ch_o == 5'd3) wr_hi3++;
      if (cycle_done_o) done_cnt++;
      if (wr2) begin
        nw2++;
        if (ch2 == 5'd0) log2_q.push_back(dat2);
      end
      if (done2) done2_cnt++;
    end
  end

  // ---------------- scoreboard / tasks ----------------
  logic [20:0] exp_q[$];
  int n_chk = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; enable = 1'b0; enable2 = 1'b0; clr = 1'b1; hold_en = 1'b0;
    slow_mask = '0; fast_mask = '0; hold_mask = '0; fast2 = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0; clr = 1'b0;
  endtask

  task automatic wait_done(input int n, input string tag);
    for (int i = 0; i < 5000 && done_cnt < n; i++) @(negedge clk);
    chk(tag, done_cnt, n);
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_n"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) chk(tag, log_q[i], exp_q[i]);
  endtask

  task automatic chk_scaler(input string tag, input logic [4:0] s, input logic [15:0] exp);
    sel = s;
    #1;
    chk(tag, scaler_o, exp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int lat;
    do_reset();
    chk("rst_wr", thresh_wr_o, 0);
    chk("rst_ch", thresh_ch_o, 0);
    chk("rst_dat", thresh_dat_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", cycle_done_o, 0);
    chk("rst_tmo", timeout_o, 0);
    chk_scaler("rst_scal", 5'd0, 16'h0000);

    // 1: no triggers -> every channel stepped down once, in order
    enable = 1'b1;
    lat = 0;
    for (int i = 0; i < 200 && !thresh_wr_o; i++) begin
      @(negedge clk);
      lat++;
    end
    chk("t1_latency", lat, GATE + 3);
    for (int c = 0; c < NCH; c++) exp_q.push_back({5'(c), 16'h7FF0});
    wait_done(1, "t1_done");
    check_log("t1_log");
    chk("t1_tmo", timeout_o, 0);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("t1_done_once", done_cnt, 1);

    // 2: ch5 at 20 edges/gate, others at 10 -> only ch5 stepped up
    do_reset();
    fast_mask = 24'h000020;
    slow_mask = 24'hFFFFDF;
    enable = 1'b1;
    exp_q.push_back({5'd5, 16'h8010});
    wait_done(1, "t2_done");
    check_log("t2_log");
    chk_scaler("t2_scal5", 5'd5, 16'd20);
    chk_scaler("t2_scal0", 5'd0, 16'd10);

    // 6a: enable dropped mid-gate -> idle next cycle, scalers kept
    repeat (10) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("t6_idle_busy", busy_o, 0);
    repeat (60) @(negedge clk);
    chk("t6_no_write", log_q.size(), 1);
    chk_scaler("t6_scal5", 5'd5, 16'd20);
    chk_scaler("t6_scal0", 5'd0, 16'd10);

    // 5: ch7 held high through the gate counts a single edge
    do_reset();
    enable = 1'b1;
    repeat (3) @(negedge clk);
    hold_mask = 24'h000080;
    wait_done(1, "t5_done");
    chk_scaler("t5_scal7", 5'd7, 16'd1);
    chk_scaler("t5_scal6", 5'd6, 16'd0);
    chk_scaler("t5_sel_oob", 5'd30, 16'd0);
    enable = 1'b0;

    // 4: ack withheld on ch3 -> timeout, ch4 still served, ch3 threshold untouched
    do_reset();
    hold_en = 1'b1;
    hold_ch = 5'd3;
    enable = 1'b1;
    for (int c = 0; c < NCH; c++) if (c != 3) exp_q.push_back({5'(c), 16'h7FF0});
    wait_done(1, "t4_done1");
    check_log("t4_log1");
    chk("t4_tmo", timeout_o, 1);
    chk("t4_wr_cycles", wr_hi3, 255);
    hold_en = 1'b0;
    log_q.delete();
    exp_q.delete();
    for (int c = 0; c < NCH; c++) exp_q.push_back({5'(c), (c == 3) ? 16'h7FF0 : 16'h7FE0});
    wait_done(2, "t4_done2");
    check_log("t4_log2");
    enable = 1'b0;

    // 6b: enable dropped while a write waits for ack -> handshake finishes, then idle
    do_reset();
    hold_en = 1'b1;
    hold_ch = 5'd0;
    enable = 1'b1;
    for (int i = 0; i < 200 && !thresh_wr_o; i++) @(negedge clk);
    chk("t6w_wr_seen", thresh_wr_o, 1);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6w_wr_held", thresh_wr_o, 1);
    chk("t6w_busy_held", busy_o, 1);
    hold_en = 1'b0;
    for (int i = 0; i < 20 && busy_o; i++) @(negedge clk);
    chk("t6w_idle", busy_o, 0);
    exp_q.push_back({5'd0, 16'h7FF0});
    check_log("t6w_log");
    chk("t6w_no_done", done_cnt, 0);
    chk("t6w_tmo", timeout_o, 0);

    // 3 + saturation: second instance starts ch0 at 0xFEF8 with a 4-bit scaler
    do_reset();
    fast2 = 1'b1;
    enable2 = 1'b1;
    for (int i = 0; i < 5000 && done2_cnt < 2; i++) @(negedge clk);
    chk("t3_done2", done2_cnt, 2);
    enable2 = 1'b0;
    chk("t3_ch0_writes", log2_q.size(), 1);
    if (log2_q.size() > 0) chk("t3_ch0_clamp", log2_q[0], 16'hFF00);
    chk("t3_total_writes", nw2, 7);
    sel2 = 5'd0;
    #1;
    chk("t5_sat", scal2, 4'hF);
    sel2 = 5'd1;
    #1;
    chk("t3_scal1", scal2, 4'h0);
    sel2 = 5'd5;
    #1;
    chk("t3_sel_oob", scal2, 4'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
